array_sram_ctrl: RTL and testbench
==================================

Name: array_sram_ctrl

Overview:
- Request-side controller directly upstream of the 32-set x 2-way x 10-bit single-port array macro (RW0_* interface, 1-cycle read latency, per-way write mask).
- After reset, zero-fills every set, then arbitrates independent read and write request channels onto the single port (write has priority).
- Returns read data one cycle after acceptance and holds it stable until the next read response.

Parameters:
- SETS, 32, number of sets; must be a power of two.
- ADDR_W, 5, set index width; equals log2(SETS).
- WAYS, 2, number of mask lanes (ways).
- WAY_W, 10, bits per way.

Ports:
- clock  in  1  single clock; also drives the macro RW0_clk.
- reset  in  1  asynchronous, active-high reset.
- init_done  out  1  high once the zero-fill sweep is complete.
- r_req_valid  in  1  read request valid.
- r_req_ready  out  1  read request accepted this cycle when valid & ready.
- r_req_setIdx  in  ADDR_W  set index to read.
- r_resp_valid  out  1  one-cycle pulse; read data valid.
- r_resp_data  out  WAYS*WAY_W  read data; held after the pulse.
- w_req_valid  in  1  write request valid.
- w_req_ready  out  1  write request accepted this cycle when valid & ready.
- w_req_setIdx  in  ADDR_W  set index to write.
- w_req_data  in  WAYS*WAY_W  write data; way i occupies bits [i*WAY_W +: WAY_W].
- w_req_waymask  in  WAYS  per-way write enable.
- sram_addr  out  ADDR_W  macro address.
- sram_en  out  1  macro enable.
- sram_wmode  out  1  macro write mode (1 = write).
- sram_wmask  out  WAYS  macro lane mask.
- sram_wdata  out  WAYS*WAY_W  macro write data.
- sram_rdata  in  WAYS*WAY_W  macro read data.

Behaviour:
- Reset:
  - State = INIT, init counter = 0, init_done = 0.
  - r_resp_valid = 0, hold register = 0.
  - Both ready outputs low.
  - While reset is high: sram_en = 0.
- INIT state:
  - Each cycle drive sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=counter.
  - Counter increments each cycle; requests are ignored and both readys are 0.
  - The cycle with counter = SETS-1 is the last write. Next cycle: state = IDLE, init_done = 1.
  - init_done therefore rises exactly SETS cycles after reset deassertion.
- IDLE state (terminal until reset):
  - w_req_ready = 1.
  - r_req_ready = !w_req_valid (write priority).
  - Readys are combinational from state and w_req_valid. Neither depends on r_req_valid.
- Write fire (w_req_valid):
  - sram_en=1, sram_wmode=1, sram_addr=w_req_setIdx, sram_wmask=w_req_waymask, sram_wdata=w_req_data, all in the same cycle.
  - A waymask of 0 is still accepted and consumes the port cycle, but writes no lanes.
- Read fire (r_req_valid & r_req_ready):
  - sram_en=1, sram_wmode=0, sram_addr=r_req_setIdx.
  - sram_wmask and sram_wdata are don't-care; drive 0.
- Idle cycle (no fire): sram_en=0; the other macro outputs are 0.
- Read response:
  - r_resp_valid=1 exactly one cycle after the read fire.
  - During that cycle r_resp_data = sram_rdata (pass-through), and the value is captured into the hold register at the cycle's end.
  - At all other times r_resp_data = hold register.
  - The hold protects against later writes to the same set changing macro output.
- Back-to-back reads: one per cycle, full throughput. Responses arrive in request order.
- Write to set S in the cycle after a read of S (the response cycle): the response returns the pre-write contents. No bypass.
- Write and read to S in the same cycle: the write wins and the read stalls. The next read of S returns the new data.
- Reset asserted mid-operation (any state): immediate return to INIT; any in-flight response is dropped (r_resp_valid = 0). After release, the full sweep repeats.
- Widths: the init counter is ADDR_W+1 bits so that termination compares cleanly without wrap ambiguity.

Decomposition:
- Shared package array_sram_pkg holds:
  - the state enum {INIT, IDLE};
  - default geometry constants (SETS, WAYS, WAY_W);
  - a function giving the lane slice offset.
- One natural sub-module, array_init_sweeper: the counter plus done flag, with outputs active, addr, and done. It is reused by other array controllers. All remaining logic stays flat in array_sram_ctrl.

Test Plan:
- Init sweep:
  - Release reset at cycle 0, then check init_done = 0 for cycles 0–31 and 1 at cycle 32.
  - sram_addr must step 0..31 with wmode=1, wmask=2'b11, wdata=0.
  - After init, reads of sets 0, 17, and 31 return 20'h0.
- Masked write then read:
  - Write set 5, data 20'hABCDE, mask 2'b01, then read set 5.
  - r_resp_valid pulses one cycle after the read fire with data 20'h000DE (bits [9:0]=10'h0DE, upper lane 0).
  - Then write mask 2'b10 with data 20'h12345 and read set 5: the response is 20'h120DE.
- Priority:
  - In the same cycle, w_req_valid (set 3, 20'hFFFFF, mask 11) and r_req_valid (set 3).
  - Required: r_req_ready=0 and the write fires. Next cycle the read fires; its response is 20'hFFFFF.
- Hold:
  - Read set 7 (contents 20'h00055); the response pulse carries 20'h00055.
  - Next cycle write set 7 with 20'h3FF00; r_resp_data must stay 20'h00055 until the next read response.
- Throughput/ordering: reads of sets 1, 2, 3 in consecutive cycles give r_resp_valid high for 3 consecutive cycles, with data in order 1, 2, 3.
- Mid-op reset:
  - Assert reset during a read fire.
  - Required: r_resp_valid stays 0, init_done drops immediately, and after release the sweep restarts at addr 0 and clears the previously written set 5 to 0.

Source files
------------

// File: rtl/array_sram_pkg.sv
// Shared geometry, state encoding and lane helpers for the
// array SRAM request controllers.
package array_sram_pkg;

  localparam int SETS   = 32;
  localparam int WAYS   = 2;
  localparam int WAY_W  = 10;
  localparam int ADDR_W = $clog2(SETS);

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  function automatic int lane_lo(input int way);
    return way * WAY_W;
  endfunction

endpackage

// File: rtl/array_sram_ctrl_if.sv
// Request/response channels plus the RW0 macro port of the
// array SRAM controller.
interface array_sram_ctrl_if
  import array_sram_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int NW = WAYS,
  parameter int WW = WAY_W
);

  localparam int DW = NW * WW;

  logic          r_req_valid;
  logic          r_req_ready;
  logic [AW-1:0] r_req_setIdx;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_data;

  logic          w_req_valid;
  logic          w_req_ready;
  logic [AW-1:0] w_req_setIdx;
  logic [DW-1:0] w_req_data;
  logic [NW-1:0] w_req_waymask;

  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [NW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  r_req_valid, r_req_setIdx,
    input  w_req_valid, w_req_setIdx,
    input  w_req_data, w_req_waymask,
    input  sram_rdata,
    output r_req_ready, r_resp_valid,
    output r_resp_data, w_req_ready,
    output sram_addr, sram_en, sram_wmode,
    output sram_wmask, sram_wdata
  );

  modport master (
    output r_req_valid, r_req_setIdx,
    output w_req_valid, w_req_setIdx,
    output w_req_data, w_req_waymask,
    output sram_rdata,
    input  r_req_ready, r_resp_valid,
    input  r_resp_data, w_req_ready,
    input  sram_addr, sram_en, sram_wmode,
    input  sram_wmask, sram_wdata
  );

endinterface

// File: rtl/array_init_sweeper.sv
// Post-reset address sweep: walks every set once, then
// raises done and stays idle until the next reset.
module array_init_sweeper #(
  parameter int SETS   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              active,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(SETS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (!done_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign active = !done_q;
  assign addr   = cnt_q[ADDR_W-1:0];
  assign done   = done_q;

endmodule

// File: rtl/array_sram_ctrl.sv
// Zero-fills the array after reset, then muxes read/write
// requests onto the single RW port and holds read data.
module array_sram_ctrl
  import array_sram_pkg::*;
#(
  parameter int SETS   = array_sram_pkg::SETS,
  parameter int ADDR_W = array_sram_pkg::ADDR_W,
  parameter int WAYS   = array_sram_pkg::WAYS,
  parameter int WAY_W  = array_sram_pkg::WAY_W
) (
  input  logic clock,
  input  logic reset,
  output logic init_done,
  array_sram_ctrl_if.slave bus
);

  localparam int DW = WAYS * WAY_W;

  logic              sw_active;
  logic              sw_done;
  logic [ADDR_W-1:0] sw_addr;
  state_e            state;
  logic              wr_fire;
  logic              rd_fire;

  logic              resp_valid_q, resp_valid_d;
  logic [DW-1:0]     hold_q, hold_d;

  array_init_sweeper #(
    .SETS   (SETS),
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk    (clock),
    .rst    (reset),
    .active (sw_active),
    .addr   (sw_addr),
    .done   (sw_done)
  );

  assign state     = sw_done ? IDLE : INIT;
  assign init_done = sw_done;

  // Write always wins the port; read waits a cycle.
  assign bus.w_req_ready = (state == IDLE);
  assign bus.r_req_ready = (state == IDLE)
                         && !bus.w_req_valid;

  assign wr_fire = (state == IDLE) && bus.w_req_valid;
  assign rd_fire = bus.r_req_valid && bus.r_req_ready;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wmask = '0;
    bus.sram_wdata = '0;
    unique case (1'b1)
      sw_active: begin
        bus.sram_en    = !reset;
        bus.sram_wmode = 1'b1;
        bus.sram_addr  = sw_addr;
        bus.sram_wmask = '1;
      end
      wr_fire: begin
        bus.sram_en    = 1'b1;
        bus.sram_wmode = 1'b1;
        bus.sram_addr  = bus.w_req_setIdx;
        bus.sram_wmask = bus.w_req_waymask;
        bus.sram_wdata = bus.w_req_data;
      end
      rd_fire: begin
        bus.sram_en   = 1'b1;
        bus.sram_addr = bus.r_req_setIdx;
      end
      default: ;
    endcase
  end

  // Capture macro output so later writes cannot disturb it.
  always_comb begin
    resp_valid_d = rd_fire;
    hold_d       = hold_q;
    if (resp_valid_q) hold_d = bus.sram_rdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      hold_q       <= hold_d;
    end
  end

  assign bus.r_resp_valid = resp_valid_q;
  assign bus.r_resp_data  = resp_valid_q ? bus.sram_rdata
                                         : hold_q;

endmodule

// File: tb/tb_array_sram_ctrl.sv
// Directed bench for array_sram_ctrl with a behavioural
// macro and a read-response scoreboard.
module tb_array_sram_ctrl;
  import array_sram_pkg::*;

  localparam int DW = WAYS * WAY_W;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;

  logic clk;
  logic reset;
  logic init_done;
  int   cyc;
  int   checks;
  int   errors;

  exp_t          q[$];
  logic [DW-1:0] exp_mem [SETS];
  logic [DW-1:0] mem [SETS];
  logic [DW-1:0] rdata_q;

  array_sram_ctrl_if bus ();

  array_sram_ctrl dut (
    .clock     (clk),
    .reset     (reset),
    .init_done (init_done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural macro: 1-cycle read latency, output held.
  initial begin
    for (int i = 0; i < SETS; i++) mem[i] = DW'($urandom);
    rdata_q = DW'($urandom);
  end

  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_wmode) begin
        for (int w = 0; w < WAYS; w++)
          if (bus.sram_wmask[w])
            mem[bus.sram_addr][w*WAY_W +: WAY_W]
              <= bus.sram_wdata[w*WAY_W +: WAY_W];
      end else begin
        rdata_q <= mem[bus.sram_addr];
      end
    end
  end

  assign bus.sram_rdata = rdata_q;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_write(input logic [4:0] s,
                             input logic [DW-1:0] d,
                             input logic [1:0] m);
    for (int w = 0; w < WAYS; w++)
      if (m[w])
        exp_mem[s][lane_lo(w) +: WAY_W] =
          d[lane_lo(w) +: WAY_W];
  endtask

  task automatic do_write(input logic [4:0] s,
                          input logic [DW-1:0] d,
                          input logic [1:0] m);
    bus.w_req_valid   = 1'b1;
    bus.w_req_setIdx  = s;
    bus.w_req_data    = d;
    bus.w_req_waymask = m;
    #1;
    chk("wr_ready", 32'(bus.w_req_ready), 32'd1);
    chk("wr_port",
        32'({bus.sram_en, bus.sram_wmode, bus.sram_addr,
             bus.sram_wmask, bus.sram_wdata}),
        32'({1'b1, 1'b1, s, m, d}));
    apply_write(s, d, m);
    step();
    bus.w_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] s);
    bus.r_req_valid  = 1'b1;
    bus.r_req_setIdx = s;
    #1;
    chk("rd_ready", 32'(bus.r_req_ready), 32'd1);
    chk("rd_port",
        32'({bus.sram_en, bus.sram_wmode, bus.sram_addr,
             bus.sram_wmask, bus.sram_wdata}),
        32'({1'b1, 1'b0, s, 2'b00, 20'h0}));
    q.push_back('{d: exp_mem[s], c: cyc + 1});
    step();
    bus.r_req_valid = 1'b0;
  endtask

  task automatic sweep_check();
    bus.r_req_valid = 1'b1;
    bus.w_req_valid = 1'b1;
    for (int c = 0; c < SETS; c++) begin
      chk("init_low", 32'(init_done), 32'd0);
      chk("init_port",
          32'({bus.sram_en, bus.sram_wmode,
               bus.sram_wmask, bus.sram_wdata,
               bus.sram_addr}),
          32'({1'b1, 1'b1, 2'b11, 20'h0, 5'(c)}));
      chk("init_ready",
          32'({bus.r_req_ready, bus.w_req_ready}), 32'd0);
      if (c == SETS - 1) begin
        bus.r_req_valid = 1'b0;
        bus.w_req_valid = 1'b0;
      end
      step();
    end
    chk("init_done", 32'(init_done), 32'd1);
    chk("idle_en", 32'(bus.sram_en), 32'd0);
    chk("idle_ready",
        32'({bus.r_req_ready, bus.w_req_ready}), 32'd3);
    for (int i = 0; i < SETS; i++) exp_mem[i] = '0;
  endtask

  // Scoreboard: every response pulse must match the head.
  always @(negedge clk) begin
    if (bus.r_resp_valid) begin
      if (q.size() == 0) begin
        chk("resp_unexpected", 32'(bus.r_resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", 32'(bus.r_resp_data), 32'(e.d));
        chk("resp_cycle", cyc, e.c);
      end
    end else if (q.size() != 0 && q[0].c < cyc) begin
      chk("resp_missing", cyc, q[0].c);
      void'(q.pop_front());
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.r_req_valid   = 1'b0;
    bus.r_req_setIdx  = '0;
    bus.w_req_valid   = 1'b0;
    bus.w_req_setIdx  = '0;
    bus.w_req_data    = '0;
    bus.w_req_waymask = '0;
    repeat (2) step();

    chk("rst_en", 32'(bus.sram_en), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_ready",
        32'({bus.r_req_ready, bus.w_req_ready}), 32'd0);
    chk("rst_resp", 32'(bus.r_resp_valid), 32'd0);
    chk("rst_hold", 32'(bus.r_resp_data), 32'd0);

    reset = 1'b0;
    #1;
    sweep_check();

    do_read(5'd0);
    do_read(5'd17);
    do_read(5'd31);
    step();

    do_write(5'd5, 20'hABCDE, 2'b01);
    do_read(5'd5);
    step();
    do_write(5'd5, 20'h12345, 2'b10);
    do_read(5'd5);
    step();
    do_write(5'd5, 20'hFFFFF, 2'b00);
    do_read(5'd5);
    step();

    // Simultaneous write and read of set 3.
    bus.w_req_valid   = 1'b1;
    bus.w_req_setIdx  = 5'd3;
    bus.w_req_data    = 20'hFFFFF;
    bus.w_req_waymask = 2'b11;
    bus.r_req_valid   = 1'b1;
    bus.r_req_setIdx  = 5'd3;
    #1;
    chk("prio_rready", 32'(bus.r_req_ready), 32'd0);
    chk("prio_port",
        32'({bus.sram_en, bus.sram_wmode, bus.sram_addr,
             bus.sram_wdata}),
        32'({1'b1, 1'b1, 5'd3, 20'hFFFFF}));
    apply_write(5'd3, 20'hFFFFF, 2'b11);
    step();
    bus.w_req_valid = 1'b0;
    do_read(5'd3);
    step();

    do_write(5'd7, 20'h00055, 2'b11);
    do_read(5'd7);
    do_write(5'd7, 20'h3FF00, 2'b11);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(bus.r_resp_valid), 32'd0);
      chk("hold_data", 32'(bus.r_resp_data), 32'h00055);
      step();
    end
    do_read(5'd7);
    step();

    do_write(5'd1, 20'h00111, 2'b11);
    do_write(5'd2, 20'h00222, 2'b11);
    do_read(5'd1);
    do_read(5'd2);
    do_read(5'd3);
    repeat (2) step();

    // Reset lands in the middle of a read fire.
    bus.r_req_valid  = 1'b1;
    bus.r_req_setIdx = 5'd9;
    #1;
    chk("mid_rready", 32'(bus.r_req_ready), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_done", 32'(init_done), 32'd0);
    chk("mid_en", 32'(bus.sram_en), 32'd0);
    chk("mid_ready",
        32'({bus.r_req_ready, bus.w_req_ready}), 32'd0);
    chk("mid_resp", 32'(bus.r_resp_valid), 32'd0);
    chk("mid_hold", 32'(bus.r_resp_data), 32'd0);
    bus.r_req_valid = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    sweep_check();
    do_read(5'd5);
    do_read(5'd7);

    for (int i = 0; i < 5 && q.size() != 0; i++) step();
    chk("drain", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
